// File: rtl/ppu_pkg.sv
// Shared loopy-register field layout, VRAM address bases and PPUDATA steps.
// Latency: none (constants and a pure function).
// Backpressure: none.
package ppu_pkg;

    // Field offsets inside the 15-bit loopy v/t registers
    localparam int CX_LSB = 0;
    localparam int CX_MSB = 4;
    localparam int CY_LSB = 5;
    localparam int CY_MSB = 9;
    localparam int NT_LSB = 10;
    localparam int NT_MSB = 11;
    localparam int FY_LSB = 12;
    localparam int FY_MSB = 14;

    // Nametable and attribute-table base addresses
    localparam logic [13:0] NT_BASE = 14'h2000;
    localparam logic [13:0] AT_BASE = 14'h23C0;

    // PPUDATA address steps: across a row or down a column
    localparam logic [14:0] INC_ACROSS = 15'd1;
    localparam logic [14:0] INC_DOWN   = 15'd32;

    // Attribute byte address for the 4x4-tile block containing v
    function automatic logic [13:0] attr_addr(input logic [14:0] v);
        return AT_BASE | {2'b00, v[NT_MSB:NT_LSB], 4'b0000, v[CY_MSB:CY_MSB-2], v[CX_MSB:CX_MSB-2]};
    endfunction

endpackage

// File: rtl/ppu_loopy_inc.sv
// Coarse-x / fine+coarse-y scroll increment of a loopy v value.
// Latency: combinational.
// Backpressure: none.
module ppu_loopy_inc
    import ppu_pkg::*;
(
    input  logic [14:0] v_in,
    input  logic        inc_x,
    input  logic        inc_y,
    output logic [14:0] v_out
);

    logic [4:0] cy;
    assign cy = v_in[CY_MSB:CY_LSB];

    // x and y touch disjoint fields, so both may apply in one pass
    always_comb begin
        v_out = v_in;
        if (inc_x) begin
            if (v_in[CX_MSB:CX_LSB] == 5'd31) begin
                v_out[CX_MSB:CX_LSB] = 5'd0;
                v_out[NT_LSB]        = ~v_in[NT_LSB];
            end else begin
                v_out[CX_MSB:CX_LSB] = v_in[CX_MSB:CX_LSB] + 5'd1;
            end
        end
        if (inc_y) begin
            if (v_in[FY_MSB:FY_LSB] != 3'd7) begin
                v_out[FY_MSB:FY_LSB] = v_in[FY_MSB:FY_LSB] + 3'd1;
            end else begin
                v_out[FY_MSB:FY_LSB] = 3'd0;
                if (cy == 5'd29) begin
                    // last visible row: wrap into the vertically adjacent nametable
                    v_out[CY_MSB:CY_LSB] = 5'd0;
                    v_out[NT_MSB]        = ~v_in[NT_MSB];
                end else if (cy == 5'd31) begin
                    // rows 30/31 live in attribute space: wrap without switching table
                    v_out[CY_MSB:CY_LSB] = 5'd0;
                end else begin
                    v_out[CY_MSB:CY_LSB] = cy + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ppu_vaddr.sv
// PPU VRAM address owner: loopy v/t, fine-x, write toggle, fetch/CPU address mux.
// Latency: address combinational; v/t/w, attr_o, cpu_data_o one cycle; read buffer refill two cycles.
// Backpressure: none; fetch strobes win the bus, colliding PPUDATA accesses are dropped (PPU_RENDER_GLITCH_EN: bump v instead).
module ppu_vaddr
    import ppu_pkg::*;
#(
    parameter int INC_ATTR_QUAD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_tile,
    input  logic        fetch_attr,
    input  logic        fetch_chr,
    input  logic [12:0] pattern_idx,
    input  logic        v_incx,
    input  logic        v_incy,
    input  logic        v_resetx,
    input  logic        v_resety,
    output logic [7:0]  data_o,
    output logic [1:0]  attr_o,
    output logic [2:0]  fine_x,
    output logic [2:0]  fine_y,
    input  logic [7:0]  ppuctrl,
    input  logic        ppuctrl_wr,
    input  logic        ppuscroll_wr,
    input  logic        ppuaddr_wr,
    input  logic        ppudata_wr,
    input  logic        ppudata_rd,
    input  logic        status_rd,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    output logic [13:0] vram_addr,
    output logic        vram_rd,
    output logic        vram_wr,
    output logic [7:0]  vram_dout,
    input  logic [7:0]  vram_din
);

    logic [14:0] v_q, t_q, v_nxt, t_nxt, v_render;
    logic [2:0]  fine_x_q, fine_x_nxt;
    logic        w_q, w_nxt, load_v;
    logic [7:0]  rbuf_q, cpu_data_q;
    logic        rd_pend_q;
    logic [1:0]  quad_q, quad_sel, attr_q, attr_now;
    logic        attr_pend_q;
    logic        any_fetch, cpu_acc, wr_go, rd_go, glitch_inc;
    logic [14:0] cpu_step;
    logic        ctrl_unused;

    assign ctrl_unused = ^{ppuctrl[7:3], ppuctrl[1:0]};

    assign any_fetch = fetch_tile | fetch_attr | fetch_chr;
    assign cpu_acc   = ppudata_wr | ppudata_rd;
    assign wr_go     = ppudata_wr & ~any_fetch;
    assign rd_go     = ppudata_rd & ~ppudata_wr & ~any_fetch;
    assign cpu_step  = ppuctrl[2] ? INC_DOWN : INC_ACROSS;

`ifdef PPU_RENDER_GLITCH_EN
    // A PPUDATA access that collides with rendering bumps v in both axes, as the real PPU does
    assign glitch_inc = cpu_acc & any_fetch;
`else
    assign glitch_inc = 1'b0;
`endif

    ppu_loopy_inc u_inc (
        .v_in  (v_q),
        .inc_x (v_incx | glitch_inc),
        .inc_y (v_incy | glitch_inc),
        .v_out (v_render)
    );

    assign fine_x     = fine_x_q;
    assign fine_y     = v_q[FY_MSB:FY_LSB];
    assign data_o     = vram_din;
    assign cpu_data_o = cpu_data_q;
    assign vram_wr    = wr_go;
    assign vram_rd    = rd_go;
    assign vram_dout  = wr_go ? cpu_data_i : 8'h00;

    // VRAM address mux: pattern > attribute > nametable > CPU
    always_comb begin
        vram_addr = v_q[13:0];
        if (fetch_chr) begin
            vram_addr = {1'b0, pattern_idx};
        end else if (fetch_attr) begin
            vram_addr = attr_addr(v_q);
        end else if (fetch_tile) begin
            vram_addr = NT_BASE | {2'b00, v_q[11:0]};
        end
    end

    // Attribute bits: bypass straight from the returning byte, then hold
    always_comb begin
        quad_sel = (INC_ATTR_QUAD != 0) ? quad_q : {v_q[6], v_q[1]};
        case (quad_sel)
            2'd0:    attr_now = vram_din[1:0];
            2'd1:    attr_now = vram_din[3:2];
            2'd2:    attr_now = vram_din[5:4];
            default: attr_now = vram_din[7:6];
        endcase
        attr_o = attr_pend_q ? attr_now : attr_q;
    end

    // CPU register writes into t / fine-x / write toggle
    always_comb begin
        t_nxt      = t_q;
        w_nxt      = w_q;
        fine_x_nxt = fine_x_q;
        load_v     = 1'b0;
        if (status_rd) begin
            w_nxt = 1'b0;
        end
        if (ppuctrl_wr) begin
            t_nxt[NT_MSB:NT_LSB] = cpu_data_i[1:0];
        end
        if (ppuscroll_wr) begin
            if (!w_q) begin
                t_nxt[CX_MSB:CX_LSB] = cpu_data_i[7:3];
                fine_x_nxt           = cpu_data_i[2:0];
                w_nxt                = 1'b1;
            end else begin
                t_nxt[FY_MSB:FY_LSB] = cpu_data_i[2:0];
                t_nxt[CY_MSB:CY_LSB] = cpu_data_i[7:3];
                w_nxt                = 1'b0;
            end
        end
        if (ppuaddr_wr) begin
            if (!w_q) begin
                t_nxt[13:8] = cpu_data_i[5:0];
                t_nxt[14]   = 1'b0;
                w_nxt       = 1'b1;
            end else begin
                t_nxt[7:0] = cpu_data_i;
                load_v     = 1'b1;
                w_nxt      = 1'b0;
            end
        end
    end

    // v update: render increments, then field reloads, then CPU step, then PPUADDR load
    always_comb begin
        v_nxt = v_render;
        if (v_resetx) begin
            v_nxt[CX_MSB:CX_LSB] = t_q[CX_MSB:CX_LSB];
            v_nxt[NT_LSB]        = t_q[NT_LSB];
        end
        if (v_resety) begin
            v_nxt[FY_MSB:NT_MSB] = t_q[FY_MSB:NT_MSB];
            v_nxt[CY_MSB:CY_LSB] = t_q[CY_MSB:CY_LSB];
        end
        // the renderer is idle whenever the CPU owns the bus, so its step wins here
        if (wr_go || rd_go) begin
            v_nxt = v_q + cpu_step;
        end
        if (load_v) begin
            v_nxt = t_nxt;
        end
    end

    // Scroll / address state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            t_q      <= '0;
            w_q      <= 1'b0;
            fine_x_q <= '0;
        end else begin
            v_q      <= v_nxt;
            t_q      <= t_nxt;
            w_q      <= w_nxt;
            fine_x_q <= fine_x_nxt;
        end
    end

    // Attribute quadrant capture and hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            quad_q      <= '0;
            attr_pend_q <= 1'b0;
            attr_q      <= '0;
        end else begin
            attr_pend_q <= fetch_attr & ~fetch_chr;
            if (fetch_attr) begin
                quad_q <= {v_q[6], v_q[1]};
            end
            if (attr_pend_q) begin
                attr_q <= attr_now;
            end
        end
    end

    // PPUDATA read pipeline: hand out the old buffer, refill it when VRAM answers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rbuf_q     <= '0;
            cpu_data_q <= '0;
        end else begin
            rd_pend_q <= rd_go;
            if (rd_go) begin
                cpu_data_q <= rbuf_q;
            end
            if (rd_pend_q) begin
                rbuf_q <= vram_din;
            end
        end
    end

endmodule

// File: tb/tb_ppu_vaddr.sv
module tb_ppu_vaddr;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_tile, fetch_attr, fetch_chr;
    logic [12:0] pattern_idx;
    logic        v_incx, v_incy, v_resetx, v_resety;
    logic [7:0]  data_o;
    logic [1:0]  attr_o;
    logic [2:0]  fine_x, fine_y;
    logic [7:0]  ppuctrl;
    logic        ppuctrl_wr, ppuscroll_wr, ppuaddr_wr, ppudata_wr, ppudata_rd, status_rd;
    logic [7:0]  cpu_data_i, cpu_data_o;
    logic [13:0] vram_addr;
    logic        vram_rd, vram_wr;
    logic [7:0]  vram_dout;
    logic [7:0]  vram_din = 8'h00;

    always #5 clk = ~clk;

    ppu_vaddr #(.INC_ATTR_QUAD(1)) dut (
        .clk(clk), .rst(rst),
        .fetch_tile(fetch_tile), .fetch_attr(fetch_attr), .fetch_chr(fetch_chr),
        .pattern_idx(pattern_idx),
        .v_incx(v_incx), .v_incy(v_incy), .v_resetx(v_resetx), .v_resety(v_resety),
        .data_o(data_o), .attr_o(attr_o), .fine_x(fine_x), .fine_y(fine_y),
        .ppuctrl(ppuctrl), .ppuctrl_wr(ppuctrl_wr), .ppuscroll_wr(ppuscroll_wr),
        .ppuaddr_wr(ppuaddr_wr), .ppudata_wr(ppudata_wr), .ppudata_rd(ppudata_rd),
        .status_rd(status_rd), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr),
        .vram_dout(vram_dout), .vram_din(vram_din)
    );

    // Synchronous VRAM model, cleared on the first clock
    logic [7:0] mem [0:16383];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
            mem_ready <= 1'b1;
        end else begin
            if (vram_wr) mem[vram_addr] <= vram_dout;
            vram_din <= mem[vram_addr];
        end
    end

    int checks = 0;
    int passes = 0;
    logic [14:0] v_q[$];
    logic [7:0]  rd_q[$];
    logic [1:0]  at_q[$];

    typedef struct {
        logic [14:0] v0;
        logic        incx;
        logic        incy;
        logic [14:0] exp_v;
    } inc_vec_t;

    typedef struct {
        logic [14:0] v0;
        logic [13:0] exp_tile;
        logic [1:0]  exp_attr;
    } attr_vec_t;

    inc_vec_t  inc_tab[10];
    attr_vec_t attr_tab[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_v(input string nm, input logic [14:0] exp);
        chk({nm, "_addr"}, 32'(vram_addr), 32'(exp[13:0]));
        chk({nm, "_fine_y"}, 32'(fine_y), 32'(exp[14:12]));
    endtask

    task automatic pop_v(input string nm);
        logic [14:0] e;
        if (v_q.size() == 0) begin
            checks++;
            $display("FAIL %s: got empty scoreboard expected an entry", nm);
        end else begin
            e = v_q.pop_front();
            chk_v(nm, e);
        end
    endtask

    task automatic pop_rd(input string nm);
        logic [7:0] e;
        if (rd_q.size() == 0) begin
            checks++;
            $display("FAIL %s: got empty scoreboard expected an entry", nm);
        end else begin
            e = rd_q.pop_front();
            chk(nm, 32'(cpu_data_o), 32'(e));
        end
    endtask

    task automatic pop_at(input string nm);
        logic [1:0] e;
        if (at_q.size() == 0) begin
            checks++;
            $display("FAIL %s: got empty scoreboard expected an entry", nm);
        end else begin
            e = at_q.pop_front();
            chk(nm, 32'(attr_o), 32'(e));
        end
    endtask

    task automatic idle();
        fetch_tile = 0; fetch_attr = 0; fetch_chr = 0;
        v_incx = 0; v_incy = 0; v_resetx = 0; v_resety = 0;
        ppuctrl_wr = 0; ppuscroll_wr = 0; ppuaddr_wr = 0;
        ppudata_wr = 0; ppudata_rd = 0; status_rd = 0;
        cpu_data_i = 8'h00;
    endtask

    // Hold the currently driven inputs across one active edge, then go idle
    task automatic pulse();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic cpu_wr(input int which, input logic [7:0] d);
        cpu_data_i = d;
        case (which)
            0: ppuctrl_wr = 1;
            1: ppuscroll_wr = 1;
            default: ppuaddr_wr = 1;
        endcase
        pulse();
    endtask

    // Load v (and t) with an arbitrary 15-bit value through PPUCTRL/PPUSCROLL + reloads
    task automatic set_v(input logic [14:0] val);
        status_rd = 1; pulse();
        cpu_wr(0, {6'b0, val[11:10]});
        cpu_wr(1, {val[4:0], 3'b000});
        cpu_wr(1, {val[9:5], val[14:12]});
        v_resetx = 1; v_resety = 1; pulse();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        inc_tab[0] = '{15'h001F, 1'b1, 1'b0, 15'h0400};
        inc_tab[1] = '{15'h73A0, 1'b0, 1'b1, 15'h0800};
        inc_tab[2] = '{15'h001F, 1'b1, 1'b1, 15'h1400};
        inc_tab[3] = '{15'h0005, 1'b1, 1'b0, 15'h0006};
        inc_tab[4] = '{15'h041F, 1'b1, 1'b0, 15'h0000};
        inc_tab[5] = '{15'h2000, 1'b0, 1'b1, 15'h3000};
        inc_tab[6] = '{15'h73E0, 1'b0, 1'b1, 15'h0000};
        inc_tab[7] = '{15'h7BA0, 1'b0, 1'b1, 15'h0000};
        inc_tab[8] = '{15'h70A0, 1'b0, 1'b1, 15'h00C0};
        inc_tab[9] = '{15'h7FFF, 1'b1, 1'b1, 15'h0800};

        // attribute byte 0xB4 = quadrants {3:2, 2:3, 1:1, 0:0}
        attr_tab[0] = '{15'h0C45, 14'h2C45, 2'd3};
        attr_tab[1] = '{15'h0C05, 14'h2C05, 2'd0};
        attr_tab[2] = '{15'h0C07, 14'h2C07, 2'd1};
        attr_tab[3] = '{15'h0C47, 14'h2C47, 2'd2};

        idle();
        ppuctrl = 8'h00;
        pattern_idx = 13'h0000;
        rst = 1;
        repeat (3) @(posedge clk);
        #1; rst = 0; #1;

        // Reset state
        chk("rst_vram_addr", 32'(vram_addr), 0);
        chk("rst_vram_rd", 32'(vram_rd), 0);
        chk("rst_vram_wr", 32'(vram_wr), 0);
        chk("rst_vram_dout", 32'(vram_dout), 0);
        chk("rst_data_o", 32'(data_o), 0);
        chk("rst_attr_o", 32'(attr_o), 0);
        chk("rst_cpu_data_o", 32'(cpu_data_o), 0);
        chk("rst_fine_x", 32'(fine_x), 0);
        chk("rst_fine_y", 32'(fine_y), 0);

        // PPUSCROLL pair then reload both axes
        cpu_wr(1, 8'h7D);
        chk("scroll_fine_x", 32'(fine_x), 5);
        cpu_wr(1, 8'h5E);
        v_resetx = 1; v_resety = 1;
        v_q.push_back(15'h616F);
        pulse();
        pop_v("scroll_reload");
        chk("scroll_fine_x2", 32'(fine_x), 5);

        // status read clears the toggle: next scroll write is an x write again
        cpu_wr(1, 8'h00);
        status_rd = 1; pulse();
        cpu_wr(1, 8'h0B);
        chk("toggle_clear_fine_x", 32'(fine_x), 3);

        // Increment table
        for (int i = 0; i < 10; i++) begin
            set_v(inc_tab[i].v0);
            v_incx = inc_tab[i].incx;
            v_incy = inc_tab[i].incy;
            v_q.push_back(inc_tab[i].exp_v);
            pulse();
            pop_v($sformatf("inc_%0d", i));
        end

        // Reload overrides the increment on the same field
        set_v(15'h001F);
        cpu_wr(1, {5'd3, 3'd0});
        status_rd = 1; pulse();
        v_incx = 1; v_resetx = 1;
        v_q.push_back(15'h0003);
        pulse();
        pop_v("resetx_over_incx");

        // Preload the attribute byte through PPUDATA
        status_rd = 1; pulse();
        cpu_wr(2, 8'h2F);
        cpu_wr(2, 8'hC1);
        ppudata_wr = 1; cpu_data_i = 8'hB4; pulse();

        // Tile / attribute fetch table
        for (int i = 0; i < 4; i++) begin
            set_v(attr_tab[i].v0);
            fetch_tile = 1; #1;
            chk($sformatf("tile_addr_%0d", i), 32'(vram_addr), 32'(attr_tab[i].exp_tile));
            pulse();
            fetch_attr = 1; #1;
            chk($sformatf("attr_addr_%0d", i), 32'(vram_addr), 32'h2FC1);
            at_q.push_back(attr_tab[i].exp_attr);
            pulse();
            chk($sformatf("attr_data_%0d", i), 32'(data_o), 32'hB4);
            pop_at($sformatf("attr_o_%0d", i));
            pulse();
            chk($sformatf("attr_hold_%0d", i), 32'(attr_o), 32'(attr_tab[i].exp_attr));
            chk_v($sformatf("fetch_keeps_v_%0d", i), attr_tab[i].v0);
        end

        // Pattern fetch wins over the others
        pattern_idx = 13'h1ABC;
        fetch_chr = 1; fetch_attr = 1; fetch_tile = 1; #1;
        chk("chr_addr", 32'(vram_addr), 32'h1ABC);
        pulse();

        // PPUDATA write, step 1
        status_rd = 1; pulse();
        cpu_wr(2, 8'h21);
        cpu_wr(2, 8'h08);
        ppudata_wr = 1; cpu_data_i = 8'hAA; #1;
        chk("wr_addr", 32'(vram_addr), 32'h2108);
        chk("wr_strobe", 32'(vram_wr), 1);
        chk("wr_rd_idle", 32'(vram_rd), 0);
        chk("wr_dout", 32'(vram_dout), 32'hAA);
        v_q.push_back(15'h2109);
        pulse();
        pop_v("wr_step1");

        // PPUDATA write, step 32
        ppuctrl = 8'h04;
        cpu_wr(2, 8'h21);
        cpu_wr(2, 8'h08);
        ppudata_wr = 1; cpu_data_i = 8'h55;
        v_q.push_back(15'h2128);
        pulse();
        pop_v("wr_step32");
        ppuctrl = 8'h00;

        // PPUDATA access colliding with a tile fetch
        set_v(15'h001F);
        ppudata_rd = 1; fetch_tile = 1; #1;
        chk("glitch_no_rd", 32'(vram_rd), 0);
        chk("glitch_tile_addr", 32'(vram_addr), 32'h201F);
`ifdef PPU_RENDER_GLITCH_EN
        v_q.push_back(15'h1400);
`else
        v_q.push_back(15'h001F);
`endif
        pulse();
        pop_v("glitch_v");

        // Reset in the middle of a PPUDATA read
        status_rd = 1; pulse();
        cpu_wr(2, 8'h21);
        cpu_wr(2, 8'h08);
        ppudata_rd = 1; rst = 1;
        pulse();
        rst = 0; #1;
        chk("midrst_cpu_data", 32'(cpu_data_o), 0);
        chk("midrst_vram_addr", 32'(vram_addr), 0);
        chk("midrst_fine_x", 32'(fine_x), 0);

        // Buffered PPUDATA reads from 0x2108
        cpu_wr(2, 8'h21);
        cpu_wr(2, 8'h08);
        ppudata_rd = 1; #1;
        chk("rd_strobe", 32'(vram_rd), 1);
        chk("rd_addr", 32'(vram_addr), 32'h2108);
        rd_q.push_back(8'h00);
        pulse();
        pop_rd("rd1_stale_buffer");
        pulse();
        ppudata_rd = 1;
        rd_q.push_back(8'h55);
        pulse();
        pop_rd("rd2_buffer_2108");
        pulse();
        ppudata_rd = 1;
        rd_q.push_back(8'h00);
        pulse();
        pop_rd("rd3_buffer_2109");
        chk_v("rd_v_after", 15'h210B);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
